// File: rtl/execute_ctrl.sv
// execute_ctrl: multi-cycle Execute sequencer (IDLE/EXEC/DONE); define EXEC_CTRL_VARSHIFT_EN to make SLLV/SRLV/SRAV legal
module execute_ctrl #(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    opcode,
  input  logic [5:0]    funct,
  input  logic [4:0]    shamt_in,
  input  logic [15:0]   imm16,
  input  logic [W-1:0]  rs_data,
  input  logic [W-1:0]  rt_data,
  input  logic [RW-1:0] rt_addr,
  input  logic [RW-1:0] rd_addr,
  output logic [W-1:0]  data_A,
  output logic [W-1:0]  data_B,
  output logic [W-1:0]  SignExtImm,
  output logic [4:0]    shamt,
  output logic [1:0]    mux_1_flag,
  output logic [3:0]    Alu_function,
  input  logic [W-1:0]  ALU,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_result,
  output logic [RW-1:0] out_rd,
  output logic          illegal
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, illegal_q, illegal_d;
  logic [W-1:0] data_a_q, data_a_d, data_b_q, data_b_d, imm_q, imm_d, result_q, result_d;
  logic [4:0] sh_q, sh_d;
  logic [1:0] mux_q, mux_d;
  logic [3:0] fn_q, fn_d;
  logic [RW-1:0] rd_q, rd_d;
  logic legal, ld_b, ld_imm, ld_sh, use_rd;
  logic [1:0] mux, a_sel;
  logic [3:0] fn;
  logic [W-1:0] imm_v;
  logic [4:0] sh_v;
  always_comb begin
    legal = 1'b1;
    fn = 4'd0;
    mux = 2'd0;
    a_sel = 2'd0;
    ld_b = 1'b0;
    ld_imm = 1'b0;
    ld_sh = 1'b0;
    use_rd = 1'b0;
    imm_v = {{(W-16){imm16[15]}}, imm16};
    sh_v = shamt_in;
    if (opcode == 6'h00) begin
      use_rd = 1'b1;
      ld_b = 1'b1;
      case (funct)
        6'h20, 6'h21: fn = 4'd0;
        6'h22, 6'h23: fn = 4'd1;
        6'h24: fn = 4'd2;
        6'h25: fn = 4'd3;
        6'h26: fn = 4'd4;
        6'h27: fn = 4'd5;
        6'h2A: fn = 4'd6;
        6'h00, 6'h02, 6'h03: begin
          fn = (funct == 6'h00) ? 4'd7 : (funct == 6'h02) ? 4'd8 : 4'd9;
          mux = 2'd2;
          a_sel = 2'd1;
          ld_b = 1'b0;
          ld_sh = 1'b1;
        end
`ifdef EXEC_CTRL_VARSHIFT_EN
        6'h04, 6'h06, 6'h07: begin
          fn = (funct == 6'h04) ? 4'd7 : (funct == 6'h06) ? 4'd8 : 4'd9;
          mux = 2'd2;
          a_sel = 2'd1;
          ld_b = 1'b0;
          ld_sh = 1'b1;
          sh_v = rs_data[4:0];
        end
`endif
        default: legal = 1'b0;
      endcase
    end else begin
      mux = 2'd1;
      ld_imm = 1'b1;
      case (opcode)
        6'h08, 6'h09: fn = 4'd0;
        6'h0A: fn = 4'd6;
        6'h0C, 6'h0D, 6'h0E: begin
          fn = (opcode == 6'h0C) ? 4'd2 : (opcode == 6'h0D) ? 4'd3 : 4'd4;
          imm_v = {{(W-16){1'b0}}, imm16};
        end
        6'h0F: begin
          fn = 4'd3;
          a_sel = 2'd2;
          imm_v = {imm16, {(W-16){1'b0}}};
        end
        default: legal = 1'b0;
      endcase
    end
  end
  always_comb begin
    state_d = state_q;
    out_valid_d = out_valid_q;
    illegal_d = illegal_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    imm_d = imm_q;
    sh_d = sh_q;
    mux_d = mux_q;
    fn_d = fn_q;
    result_d = result_q;
    rd_d = rd_q;
    if (state_q == IDLE && in_ready_q && in_valid) begin
      if (legal) begin
        state_d = EXEC;
        data_a_d = (a_sel == 2'd2) ? '0 : a_sel[0] ? rt_data : rs_data;
        data_b_d = ld_b ? rt_data : data_b_q;
        imm_d = ld_imm ? imm_v : imm_q;
        sh_d = ld_sh ? sh_v : sh_q;
        mux_d = mux;
        fn_d = fn;
        rd_d = use_rd ? rd_addr : rt_addr;
      end else begin
        state_d = DONE;
        out_valid_d = 1'b1;
        illegal_d = 1'b1;
        result_d = '0;
        rd_d = '0;
      end
    end else if (state_q == EXEC) begin
      state_d = DONE;
      out_valid_d = 1'b1;
      result_d = ALU;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
      illegal_d = 1'b0;
    end
    in_ready_d = (state_d == IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      illegal_q <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
      imm_q <= '0;
      sh_q <= '0;
      mux_q <= '0;
      fn_q <= '0;
      result_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      illegal_q <= illegal_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      imm_q <= imm_d;
      sh_q <= sh_d;
      mux_q <= mux_d;
      fn_q <= fn_d;
      result_q <= result_d;
      rd_q <= rd_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign illegal = illegal_q;
  assign data_A = data_a_q;
  assign data_B = data_b_q;
  assign SignExtImm = imm_q;
  assign shamt = sh_q;
  assign mux_1_flag = mux_q;
  assign Alu_function = fn_q;
  assign out_result = result_q;
  assign out_rd = rd_q;
endmodule
